// File: rtl/biriscv_alu_arbiter.sv
// Two-port arbiter in front of a single shared biriscv ALU.
// The granted request is registered into stage 1, the ALU result is evaluated
// from the stage-1 registers, and stage 2 holds the result with its id and tag.
module biriscv_alu_arbiter #(
  parameter int unsigned TAG_W = 4,
  parameter bit          RR_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,

  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [3:0]       req0_op_i,
  input  logic [31:0]      req0_a_i,
  input  logic [31:0]      req0_b_i,
  input  logic [TAG_W-1:0] req0_tag_i,

  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [3:0]       req1_op_i,
  input  logic [31:0]      req1_a_i,
  input  logic [31:0]      req1_b_i,
  input  logic [TAG_W-1:0] req1_tag_i,

  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic             resp_id_o,
  output logic [TAG_W-1:0] resp_tag_o,
  output logic [31:0]      resp_result_o,
  output logic             busy_o
);

  // biriscv ALU opcode encoding
  localparam logic [3:0] AluNone           = 4'b0000;
  localparam logic [3:0] AluShiftl         = 4'b0001;
  localparam logic [3:0] AluShiftr         = 4'b0010;
  localparam logic [3:0] AluShiftrArith    = 4'b0011;
  localparam logic [3:0] AluAdd            = 4'b0100;
  localparam logic [3:0] AluSub            = 4'b0110;
  localparam logic [3:0] AluAnd            = 4'b0111;
  localparam logic [3:0] AluOr             = 4'b1000;
  localparam logic [3:0] AluXor            = 4'b1001;
  localparam logic [3:0] AluLessThan       = 4'b1010;
  localparam logic [3:0] AluLessThanSigned = 4'b1011;

  logic             s1_valid_q, s2_valid_q;
  logic             rr_ptr_q;   // 1: port 1 preferred on contention
  logic [3:0]       s1_op_q;
  logic [31:0]      s1_a_q, s1_b_q;
  logic             s1_id_q, s2_id_q;
  logic [TAG_W-1:0] s1_tag_q, s2_tag_q;
  logic [31:0]      s2_result_q;

  logic both_valid, grant0, grant1, s1_ready, s2_ready, accept;
  logic [31:0] alu_p;

  // Arbitration and pipeline handshake
  always_comb begin
    both_valid   = req0_valid_i & req1_valid_i;
    grant1       = req1_valid_i & (~req0_valid_i | (RR_EN & rr_ptr_q));
    grant0       = req0_valid_i & ~grant1;
    s2_ready     = ~s2_valid_q | resp_ready_i;
    s1_ready     = ~s1_valid_q | s2_ready;
    req0_ready_o = grant0 & s1_ready & ~flush_i;
    req1_ready_o = grant1 & s1_ready & ~flush_i;
    accept       = req0_ready_o | req1_ready_o;
  end

  // Shared ALU evaluated from the stage-1 registers
  always_comb begin
    alu_p = s1_a_q;
    unique case (s1_op_q)
      AluShiftl:         alu_p = s1_a_q << s1_b_q[4:0];
      AluShiftr:         alu_p = s1_a_q >> s1_b_q[4:0];
      AluShiftrArith:    alu_p = $signed(s1_a_q) >>> s1_b_q[4:0];
      AluAdd:            alu_p = s1_a_q + s1_b_q;
      AluSub:            alu_p = s1_a_q - s1_b_q;
      AluAnd:            alu_p = s1_a_q & s1_b_q;
      AluOr:             alu_p = s1_a_q | s1_b_q;
      AluXor:            alu_p = s1_a_q ^ s1_b_q;
      AluLessThan:       alu_p = {31'b0, s1_a_q < s1_b_q};
      AluLessThanSigned: alu_p = {31'b0, $signed(s1_a_q) < $signed(s1_b_q)};
      AluNone:           alu_p = s1_a_q;
      default:           alu_p = s1_a_q;
    endcase
  end

  // Valid bits and round-robin pointer; flush wins over everything
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      rr_ptr_q   <= 1'b0;
    end else if (flush_i) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      if (s1_ready) s1_valid_q <= accept;
      if (s2_ready) s2_valid_q <= s1_valid_q;
      if (accept && both_valid) rr_ptr_q <= grant0;
    end
  end

  // Stage-1 operand capture on an accepted request
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_op_q  <= '0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_id_q  <= 1'b0;
      s1_tag_q <= '0;
    end else if (accept) begin
      s1_op_q  <= grant1 ? req1_op_i  : req0_op_i;
      s1_a_q   <= grant1 ? req1_a_i   : req0_a_i;
      s1_b_q   <= grant1 ? req1_b_i   : req0_b_i;
      s1_id_q  <= grant1;
      s1_tag_q <= grant1 ? req1_tag_i : req0_tag_i;
    end
  end

  // Stage-2 result capture when stage 1 advances
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_result_q <= '0;
      s2_id_q     <= 1'b0;
      s2_tag_q    <= '0;
    end else if (s1_valid_q && s2_ready && !flush_i) begin
      s2_result_q <= alu_p;
      s2_id_q     <= s1_id_q;
      s2_tag_q    <= s1_tag_q;
    end
  end

  assign resp_valid_o  = s2_valid_q;
  assign resp_id_o     = s2_id_q;
  assign resp_tag_o    = s2_tag_q;
  assign resp_result_o = s2_result_q;
  assign busy_o        = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_biriscv_alu_arbiter.sv
// Directed bench for biriscv_alu_arbiter: ALU vector table through the pipe,
// then round-robin, fixed-priority, backpressure, flush and async-reset sequences.
module tb_biriscv_alu_arbiter;

  localparam logic [3:0] OpNone  = 4'b0000;
  localparam logic [3:0] OpSll   = 4'b0001;
  localparam logic [3:0] OpSrl   = 4'b0010;
  localparam logic [3:0] OpSra   = 4'b0011;
  localparam logic [3:0] OpAdd   = 4'b0100;
  localparam logic [3:0] OpSub   = 4'b0110;
  localparam logic [3:0] OpAnd   = 4'b0111;
  localparam logic [3:0] OpOr    = 4'b1000;
  localparam logic [3:0] OpXor   = 4'b1001;
  localparam logic [3:0] OpSltu  = 4'b1010;
  localparam logic [3:0] OpSlt   = 4'b1011;

  logic        clk, rst_n, flush, resp_ready;
  logic        r0_valid, r1_valid;
  logic [3:0]  r0_op, r1_op, r0_tag, r1_tag;
  logic [31:0] r0_a, r0_b, r1_a, r1_b;

  logic        ready0, ready1, resp_valid, resp_id, busy;
  logic [3:0]  resp_tag;
  logic [31:0] resp_result;

  logic        fp_ready0, fp_ready1, fp_resp_valid, fp_resp_id, fp_busy;
  logic [3:0]  fp_resp_tag;
  logic [31:0] fp_resp_result;

  int tests = 0;
  int fails = 0;

  biriscv_alu_arbiter #(.TAG_W(4), .RR_EN(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req0_valid_i(r0_valid), .req0_ready_o(ready0), .req0_op_i(r0_op),
    .req0_a_i(r0_a), .req0_b_i(r0_b), .req0_tag_i(r0_tag),
    .req1_valid_i(r1_valid), .req1_ready_o(ready1), .req1_op_i(r1_op),
    .req1_a_i(r1_a), .req1_b_i(r1_b), .req1_tag_i(r1_tag),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_id_o(resp_id),
    .resp_tag_o(resp_tag), .resp_result_o(resp_result), .busy_o(busy)
  );

  biriscv_alu_arbiter #(.TAG_W(4), .RR_EN(1'b0)) dut_fp (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req0_valid_i(r0_valid), .req0_ready_o(fp_ready0), .req0_op_i(r0_op),
    .req0_a_i(r0_a), .req0_b_i(r0_b), .req0_tag_i(r0_tag),
    .req1_valid_i(r1_valid), .req1_ready_o(fp_ready1), .req1_op_i(r1_op),
    .req1_a_i(r1_a), .req1_b_i(r1_b), .req1_tag_i(r1_tag),
    .resp_valid_o(fp_resp_valid), .resp_ready_i(resp_ready), .resp_id_o(fp_resp_id),
    .resp_tag_o(fp_resp_tag), .resp_result_o(fp_resp_result), .busy_o(fp_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        port;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } bp_t;

  vec_t vecs[12];
  bp_t  bp[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_reqs();
    r0_valid = 1'b0;
    r1_valid = 1'b0;
  endtask

  task automatic drive0(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag);
    r0_valid = 1'b1; r0_op = op; r0_a = a; r0_b = b; r0_tag = tag;
  endtask

  task automatic drive1(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag);
    r1_valid = 1'b1; r1_op = op; r1_a = a; r1_b = b; r1_tag = tag;
  endtask

  initial begin
    int pi;
    int ri;
    logic acc;

    vecs[0]  = '{1'b0, OpAdd,  32'd5,        32'd7,        4'd3,  32'd12};
    vecs[1]  = '{1'b1, OpSub,  32'd10,       32'd3,        4'd1,  32'd7};
    vecs[2]  = '{1'b0, OpXor,  32'hFFFF0000, 32'h0000FFFF, 4'd2,  32'hFFFFFFFF};
    vecs[3]  = '{1'b1, OpSll,  32'h00000001, 32'h00000021, 4'd4,  32'h00000002};
    vecs[4]  = '{1'b0, OpSrl,  32'h80000000, 32'd4,        4'd5,  32'h08000000};
    vecs[5]  = '{1'b1, OpSra,  32'h80000000, 32'd4,        4'd6,  32'hF8000000};
    vecs[6]  = '{1'b0, OpAnd,  32'hF0F0F0F0, 32'h0FF00FF0, 4'd7,  32'h00F000F0};
    vecs[7]  = '{1'b1, OpOr,   32'h00000F00, 32'h000000F0, 4'd8,  32'h00000FF0};
    vecs[8]  = '{1'b0, OpSlt,  32'hFFFFFFFF, 32'd1,        4'd9,  32'd1};
    vecs[9]  = '{1'b1, OpSltu, 32'hFFFFFFFF, 32'd1,        4'd10, 32'd0};
    vecs[10] = '{1'b0, 4'hF,   32'hDEADBEEF, 32'd9,        4'd11, 32'hDEADBEEF};
    vecs[11] = '{1'b1, OpNone, 32'h12345678, 32'd9,        4'd12, 32'h12345678};

    bp[0] = '{OpSra, 32'h80000000, 32'd4, 32'hF8000000};
    bp[1] = '{OpAdd, 32'd1,        32'd1, 32'd2};
    bp[2] = '{OpSub, 32'd5,        32'd2, 32'd3};
    bp[3] = '{OpXor, 32'h0000000F, 32'd1, 32'h0000000E};

    rst_n = 1'b0; flush = 1'b0; resp_ready = 1'b1;
    r0_valid = 1'b0; r0_op = '0; r0_a = '0; r0_b = '0; r0_tag = '0;
    r1_valid = 1'b0; r1_op = '0; r1_a = '0; r1_b = '0; r1_tag = '0;
    #2;
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_id", {31'b0, resp_id}, 32'd0);
    check("rst_resp_tag", {28'b0, resp_tag}, 32'd0);
    check("rst_resp_result", resp_result, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_readies", {30'b0, ready1, ready0}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU vector table: accept in cycle 0, result visible in cycle 2
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      clear_reqs();
      if (vecs[i].port) drive1(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      else drive0(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      settle();
      check($sformatf("vec%0d_ready", i), {30'b0, ready1, ready0},
            vecs[i].port ? 32'd2 : 32'd1);
      next_cycle();
      clear_reqs();
      settle();
      check($sformatf("vec%0d_c1_valid", i), {31'b0, resp_valid}, 32'd0);
      next_cycle();
      settle();
      check($sformatf("vec%0d_valid", i), {31'b0, resp_valid}, 32'd1);
      check($sformatf("vec%0d_id", i), {31'b0, resp_id}, {31'b0, vecs[i].port});
      check($sformatf("vec%0d_tag", i), {28'b0, resp_tag}, {28'b0, vecs[i].tag});
      check($sformatf("vec%0d_result", i), resp_result, vecs[i].exp);
    end
    next_cycle();

    // Round-robin contention: grants 0,1,0,1 and results in grant order
    r0_op = OpSub; r0_a = 32'd10; r0_b = 32'd3; r0_tag = 4'd1;
    r1_op = OpXor; r1_a = 32'hFFFF0000; r1_b = 32'h0000FFFF; r1_tag = 4'd2;
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      r0_valid = (i < 4);
      r1_valid = (i < 4);
      settle();
      if (i < 4) begin
        check($sformatf("rr%0d_grant", i), {30'b0, ready1, ready0},
              (i % 2 == 0) ? 32'd1 : 32'd2);
      end
      if (i >= 2) begin
        check($sformatf("rr%0d_valid", i), {31'b0, resp_valid}, 32'd1);
        check($sformatf("rr%0d_id", i), {31'b0, resp_id}, ((i - 2) % 2 == 0) ? 32'd0 : 32'd1);
        check($sformatf("rr%0d_result", i), resp_result,
              ((i - 2) % 2 == 0) ? 32'd7 : 32'hFFFFFFFF);
      end
    end
    clear_reqs();
    repeat (2) next_cycle();

    // Fixed priority instance: port 0 always wins, port 1 only once port 0 leaves
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      r0_valid = 1'b1;
      r1_valid = 1'b1;
      settle();
      check($sformatf("fp%0d_grant", i), {30'b0, fp_ready1, fp_ready0}, 32'd1);
      if (i >= 2) begin
        check($sformatf("fp%0d_resp", i), {fp_busy, fp_resp_valid, fp_resp_id, fp_resp_tag,
              fp_resp_result[24:0]}, {1'b1, 1'b1, 1'b0, 4'd1, 25'd7});
      end
    end
    next_cycle();
    r0_valid = 1'b0;
    settle();
    check("fp_port1_after", {30'b0, fp_ready1, fp_ready0}, 32'd2);
    next_cycle();
    clear_reqs();
    repeat (4) next_cycle();

    // Backpressure: four port-1 ops, consumer stalled until cycle 5
    pi = 0;
    ri = 0;
    for (int cyc = 0; cyc < 20 && ri < 4; cyc++) begin
      next_cycle();
      resp_ready = (cyc >= 5);
      if (pi < 4) drive1(bp[pi].op, bp[pi].a, bp[pi].b, 4'(pi + 4));
      else r1_valid = 1'b0;
      settle();
      if (cyc == 2) begin
        check("bp_accepts_before_stall", pi, 2);
        check("bp_ready_drop", {31'b0, ready1}, 32'd0);
      end
      if (cyc == 4) begin
        check("bp_hold_valid", {31'b0, resp_valid}, 32'd1);
        check("bp_hold_result", resp_result, 32'hF8000000);
      end
      acc = r1_valid & ready1;
      if (resp_valid && resp_ready) begin
        check($sformatf("bp%0d_result", ri), resp_result, bp[ri].exp);
        check($sformatf("bp%0d_tag", ri), {28'b0, resp_tag}, 32'(ri + 4));
        ri++;
      end
      if (acc) pi++;
    end
    check("bp_count", ri, 4);
    clear_reqs();
    next_cycle();
    settle();
    check("bp_no_dup", {30'b0, busy, resp_valid}, 32'd0);

    // Flush with two ops in flight; request during flush waits one cycle
    resp_ready = 1'b1;
    next_cycle();
    drive0(OpAdd, 32'd1, 32'd2, 4'd8);
    next_cycle();
    drive0(OpAdd, 32'd3, 32'd4, 4'd9);
    next_cycle();
    r0_valid = 1'b0;
    flush = 1'b1;
    drive1(OpOr, 32'h100, 32'h1, 4'd10);
    settle();
    check("flush_busy_before", {31'b0, busy}, 32'd1);
    check("flush_block", {31'b0, ready1}, 32'd0);
    next_cycle();
    flush = 1'b0;
    settle();
    check("flush_resp_cleared", {31'b0, resp_valid}, 32'd0);
    check("flush_busy_cleared", {31'b0, busy}, 32'd0);
    check("flush_then_accept", {31'b0, ready1}, 32'd1);
    next_cycle();
    r1_valid = 1'b0;
    settle();
    check("flush_c1_valid", {31'b0, resp_valid}, 32'd0);
    next_cycle();
    settle();
    check("flush_resp_valid", {31'b0, resp_valid}, 32'd1);
    check("flush_resp_id", {31'b0, resp_id}, 32'd1);
    check("flush_resp_tag", {28'b0, resp_tag}, 32'd10);
    check("flush_resp_result", resp_result, 32'h101);
    next_cycle();

    // Async reset mid-stream: pointer left at port 1 must return to port 0
    resp_ready = 1'b0;
    next_cycle();
    drive0(OpAdd, 32'd2, 32'd2, 4'd13);
    drive1(OpAdd, 32'd3, 32'd3, 4'd14);
    settle();
    check("rst_pre_grant", {30'b0, ready1, ready0}, 32'd1);
    next_cycle();
    clear_reqs();
    next_cycle();
    settle();
    check("rst_pre_valid", {31'b0, resp_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_async_busy", {31'b0, busy}, 32'd0);
    check("rst_async_result", resp_result, 32'd0);
    #2;
    rst_n = 1'b1;
    resp_ready = 1'b1;
    next_cycle();
    r0_valid = 1'b1;
    r1_valid = 1'b1;
    settle();
    check("rst_post_grant", {30'b0, ready1, ready0}, 32'd1);
    next_cycle();
    clear_reqs();
    repeat (3) next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
